// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads, full-screen clear, paint writes.
// Optional starvation guard enabled by VRAM_ARBITER_STARVE_GUARD_EN.
module vram_arbiter #(
    parameter int VRAM_L = 76800,
    parameter int STARVE_LIMIT = 4,
    localparam int A = $clog2(VRAM_L)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         disp_valid,
    input  logic [A-1:0] disp_addr,
    output logic         disp_ready,
    output logic [15:0]  disp_rdata,
    output logic         disp_rdata_valid,
    input  logic         wr_valid,
    input  logic [A-1:0] wr_addr,
    input  logic [15:0]  wr_data,
    output logic         wr_ready,
    input  logic         clear_start,
    input  logic [15:0]  clear_color,
    output logic         clear_busy,
    output logic         clear_done,
    output logic [A-1:0] mem_addr,
    output logic         mem_wr_ena,
    output logic [15:0]  mem_wr_data,
    input  logic [15:0]  mem_rd_data
);

    localparam logic [A-1:0] LAST = A'(VRAM_L - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR_RUN,
        S_CLEAR_DONE
    } state_t;

    state_t       state;
    logic [A-1:0] clr_addr;
    logic [15:0]  clr_color;
    logic         disp_win;
    logic         clear_win;
    logic         paint_win;
    logic         wr_in_range;
    logic         starve_force;

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;
    logic          writer_pend;

    assign writer_pend  = (state == S_CLEAR_RUN) | (wr_valid & ~clear_busy);
    assign starve_force = (starve_cnt == CW'(STARVE_LIMIT));

    // Any cycle that is not a display grant against a waiting writer breaks the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (disp_win && writer_pend)
            starve_cnt <= starve_cnt + 1'b1;
        else
            starve_cnt <= '0;
    end
`else
    assign starve_force = 1'b0;
`endif

    assign disp_win    = ~rst & disp_valid & ~starve_force;
    assign clear_win   = ~rst & ~disp_win & (state == S_CLEAR_RUN);
    assign paint_win   = ~rst & ~disp_win & ~clear_busy & wr_valid;
    assign wr_in_range = (wr_addr <= LAST);

    assign disp_ready = disp_win;
    assign wr_ready   = paint_win;
    assign mem_wr_ena = clear_win | (paint_win & wr_in_range);
    assign disp_rdata = mem_rd_data;

    always_comb begin
        mem_addr    = wr_addr;
        mem_wr_data = wr_data;
        if (disp_win) begin
            mem_addr = disp_addr;
        end else if (clear_win) begin
            mem_addr    = clr_addr;
            mem_wr_data = clr_color;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            clr_addr         <= '0;
            clr_color        <= '0;
            clear_busy       <= 1'b0;
            clear_done       <= 1'b0;
            disp_rdata_valid <= 1'b0;
        end else begin
            disp_rdata_valid <= disp_win;
            clear_done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (clear_start) begin
                        clr_color  <= clear_color;
                        clr_addr   <= '0;
                        clear_busy <= 1'b1;
                        state      <= S_CLEAR_RUN;
                    end
                end
                S_CLEAR_RUN: begin
                    if (clear_win) begin
                        if (clr_addr == LAST) begin
                            clear_done <= 1'b1;
                            state      <= S_CLEAR_DONE;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
                S_CLEAR_DONE: begin
                    clear_busy <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter with a behavioural synchronous VRAM
// and a read-data scoreboard queue.
module tb_vram_arbiter;

    localparam int VL = 76800;
    localparam int A  = $clog2(VL);

    logic         clk = 1'b0;
    logic         rst;
    logic         disp_valid;
    logic [A-1:0] disp_addr;
    logic         disp_ready;
    logic [15:0]  disp_rdata;
    logic         disp_rdata_valid;
    logic         wr_valid;
    logic [A-1:0] wr_addr;
    logic [15:0]  wr_data;
    logic         wr_ready;
    logic         clear_start;
    logic [15:0]  clear_color;
    logic         clear_busy;
    logic         clear_done;
    logic [A-1:0] mem_addr;
    logic         mem_wr_ena;
    logic [15:0]  mem_wr_data;
    logic [15:0]  mem_rd_data;

    logic [15:0] mem [0:VL-1];
    logic [15:0] exp_q [$];
    int n_checks = 0;
    int n_pass = 0;

    vram_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_addr(disp_addr),
        .disp_ready(disp_ready), .disp_rdata(disp_rdata),
        .disp_rdata_valid(disp_rdata_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready),
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_ena && int'(mem_addr) < VL)
            mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= (int'(mem_addr) < VL) ? mem[mem_addr] : 16'h0;
    end

    function automatic logic [15:0] pat(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        disp_valid = 1'b1; disp_addr = '0;
        wr_valid = 1'b1; wr_addr = 17'd1; wr_data = 16'hAAAA;
        clear_start = 1'b0; clear_color = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (disp_ready !== 1'b0) $display("FAIL rst_disp_ready got %b want 0", disp_ready);
        else n_pass++;
        n_checks++;
        if (wr_ready !== 1'b0) $display("FAIL rst_wr_ready got %b want 0", wr_ready);
        else n_pass++;
        n_checks++;
        if (mem_wr_ena !== 1'b0) $display("FAIL rst_mem_wr_ena got %b want 0", mem_wr_ena);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; disp_valid = 1'b0; wr_valid = 1'b0;
        #1;
        n_checks++;
        if ({clear_busy, clear_done, disp_rdata_valid} !== 3'b000)
            $display("FAIL rst_regs got %b want 000",
                     {clear_busy, clear_done, disp_rdata_valid});
        else n_pass++;
    endtask

    task automatic test_disp_read;
        int addrs [4] = '{100, 200, 201, VL - 1};
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (disp_rdata_valid !== 1'b1 || disp_rdata !== e)
                    $display("FAIL rd_data v=%b got %h want %h", disp_rdata_valid, disp_rdata, e);
                else n_pass++;
            end
            disp_valid = 1'b1;
            disp_addr = A'(addrs[i]);
            exp_q.push_back(addrs[i] == 100 ? 16'h1234 : pat(addrs[i]));
            #1;
            n_checks++;
            if (disp_ready !== 1'b1 || mem_wr_ena !== 1'b0 || mem_addr !== A'(addrs[i]))
                $display("FAIL rd_grant rdy=%b we=%b addr=%0d want 1/0/%0d",
                         disp_ready, mem_wr_ena, mem_addr, addrs[i]);
            else n_pass++;
        end
        @(negedge clk);
        disp_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (disp_rdata_valid !== 1'b1 || disp_rdata !== e)
            $display("FAIL rd_last v=%b got %h want %h", disp_rdata_valid, disp_rdata, e);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (disp_rdata_valid !== 1'b0) $display("FAIL rd_valid_drop got %b want 0", disp_rdata_valid);
        else n_pass++;
    endtask

    task automatic test_paint;
        logic [15:0] e;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 16'hF800;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || mem_wr_ena !== 1'b1 || mem_addr !== 17'd5 || mem_wr_data !== 16'hF800)
            $display("FAIL paint rdy=%b we=%b addr=%0d data=%h want 1/1/5/f800",
                     wr_ready, mem_wr_ena, mem_addr, mem_wr_data);
        else n_pass++;
        @(negedge clk);
        wr_valid = 1'b0;
        disp_valid = 1'b1; disp_addr = 17'd5;
        exp_q.push_back(16'hF800);
        @(negedge clk);
        disp_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (disp_rdata_valid !== 1'b1 || disp_rdata !== e)
            $display("FAIL paint_readback v=%b got %h want %h", disp_rdata_valid, disp_rdata, e);
        else n_pass++;
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = A'(VL); wr_data = 16'hBEEF;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || mem_wr_ena !== 1'b0)
            $display("FAIL oor rdy=%b we=%b want 1/0", wr_ready, mem_wr_ena);
        else n_pass++;
        @(negedge clk);
        wr_addr = A'(VL - 1);
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || mem_wr_ena !== 1'b1)
            $display("FAIL last_addr rdy=%b we=%b want 1/1", wr_ready, mem_wr_ena);
        else n_pass++;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_contention;
        logic ew;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            disp_valid = 1'b1; disp_addr = 17'd50;
            wr_valid = 1'b1; wr_addr = 17'd6; wr_data = 16'h0F0F;
            #1;
`ifdef VRAM_ARBITER_STARVE_GUARD_EN
            ew = (i % 5 == 4);
`else
            ew = 1'b0;
`endif
            n_checks++;
            if (wr_ready !== ew || disp_ready !== ~ew)
                $display("FAIL contend cyc%0d wr_rdy=%b disp_rdy=%b want %b/%b",
                         i, wr_ready, disp_ready, ew, ~ew);
            else n_pass++;
            @(negedge clk);
        end
        disp_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear;
        int nwr = 0;
        int errs = 0;
        int cyc = 0;
        bit done_seen = 0;
        bit rd_pend = 0;
        bit did_rd = 0;
        logic [15:0] e;
        @(negedge clk);
        clear_start = 1'b1; clear_color = 16'h001F;
        while (!done_seen && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            clear_start = 1'b0; disp_valid = 1'b0;
            wr_valid = (nwr >= 100 && nwr < 200);
            wr_addr = 17'd9; wr_data = 16'h0000;
            if (rd_pend) begin
                rd_pend = 0;
                e = exp_q.pop_front();
                n_checks++;
                if (disp_rdata_valid !== 1'b1 || disp_rdata !== e)
                    $display("FAIL clr_rd v=%b got %h want %h", disp_rdata_valid, disp_rdata, e);
                else n_pass++;
            end
            if (nwr == 300 && !did_rd) begin
                did_rd = 1;
                rd_pend = 1;
                disp_valid = 1'b1; disp_addr = 17'd3;
                clear_start = 1'b1; clear_color = 16'hFFFF;
                exp_q.push_back(16'h001F);
                #1;
                n_checks++;
                if (disp_ready !== 1'b1 || mem_wr_ena !== 1'b0)
                    $display("FAIL clr_disp_prio rdy=%b we=%b want 1/0", disp_ready, mem_wr_ena);
                else n_pass++;
            end else begin
                #1;
            end
            if (wr_ready) errs++;
            if (clear_done) begin
                done_seen = 1;
                n_checks++;
                if (clear_busy !== 1'b1) $display("FAIL clr_busy_at_done got %b want 1", clear_busy);
                else n_pass++;
            end else if (mem_wr_ena) begin
                if (mem_addr !== A'(nwr) || mem_wr_data !== 16'h001F) errs++;
                nwr++;
            end
        end
        n_checks++;
        if (!done_seen) $display("FAIL clr_timeout done=0 want 1 after %0d cycles", cyc);
        else n_pass++;
        n_checks++;
        if (nwr != VL) $display("FAIL clr_count got %0d want %0d", nwr, VL);
        else n_pass++;
        n_checks++;
        if (errs != 0) $display("FAIL clr_errors got %0d want 0", errs);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (clear_done !== 1'b0 || clear_busy !== 1'b0)
            $display("FAIL clr_end done=%b busy=%b want 0/0", clear_done, clear_busy);
        else n_pass++;
        n_checks++;
        if (mem[VL-1] !== 16'h001F || mem[0] !== 16'h001F)
            $display("FAIL clr_mem got %h/%h want 001f", mem[0], mem[VL-1]);
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        int cyc = 0;
        int bad = 0;
        @(negedge clk);
        clear_start = 1'b1; clear_color = 16'h07E0;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        while (!(mem_wr_ena && mem_addr == 17'd1000) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        n_checks++;
        if (cyc >= 2000) $display("FAIL abort_reach got timeout want addr 1000");
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (clear_busy !== 1'b0 || mem_wr_ena !== 1'b0)
            $display("FAIL abort_rst busy=%b we=%b want 0/0", clear_busy, mem_wr_ena);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (clear_done !== 1'b0 || clear_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_no_done got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (mem[999] !== 16'h07E0 || mem[1000] !== 16'h001F || mem[0] !== 16'h07E0)
            $display("FAIL abort_partial got %h/%h/%h want 07e0/07e0/001f",
                     mem[0], mem[999], mem[1000]);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < VL; i++) mem[i] = pat(i);
        mem[100] = 16'h1234;
        test_reset();
        test_disp_read();
        test_paint();
        test_out_of_range();
        test_contention();
        test_clear();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
